// File: rtl/gen_multitap.sv
`default_nettype none
// ============================================================================
// Module   : gen_multitap
// Purpose  : Multi-pad adapter for one Genesis controller port. Up to NPADS
//            pads are read through a single port with a nibble-serial
//            TH/TR/TL handshake. The host lowers TH to start a sequence and
//            toggles TR once per nibble. TL echoes TR once the new nibble is
//            on DO.
// Ports    : RESET       async active-high reset
//            CLK         system clock
//            CE          clock enable; all state advances only when CE=1
//            TH, TR      resolved host levels
//            PAD_BTN     12 bits per pad, active-low, LSB first:
//                        {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
//            PAD_PRESENT 1 = pad connected
//            PAD_6BTN    1 = six-button pad
//            DO          data nibble (D3..D0)
//            TL          handshake acknowledge
//            ACTIVE      1 while a sequence is in progress
// Revision : 1.0 - initial release
// ============================================================================
module gen_multitap #(
    parameter int NPADS = 4,
    parameter int TMO   = 11600,
    parameter int FILT  = 2
) (
    input  logic                  RESET,
    input  logic                  CLK,
    input  logic                  CE,
    input  logic                  TH,
    input  logic                  TR,
    input  logic [12*NPADS-1:0]   PAD_BTN,
    input  logic [NPADS-1:0]      PAD_PRESENT,
    input  logic [NPADS-1:0]      PAD_6BTN,
    output logic [3:0]            DO,
    output logic                  TL,
    output logic                  ACTIVE
);

    localparam int IDXW = $clog2(4 + 4*NPADS + 1);
    localparam int TMOW = $clog2(TMO + 1);
    localparam int FLTW = $clog2(FILT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input filters: index 0 = TH, index 1 = TR
    // ------------------------------------------------------------------
    logic [1:0]      raw;
    logic [1:0]      flt_q, flt_d;
    logic [1:0]      prv_q, prv_d;
    logic [FLTW-1:0] fcnt_q [2];
    logic [FLTW-1:0] fcnt_d [2];

    assign raw = {TR, TH};

    // A new level is accepted only after it has differed from the accepted
    // level for FILT consecutive CE samples; any bounce restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flt_d[i]  = flt_q[i];
            fcnt_d[i] = '0;
            if (raw[i] != flt_q[i]) begin
                if (fcnt_q[i] == FLTW'(FILT - 1)) begin
                    flt_d[i] = raw[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
        prv_d = flt_q;
    end

    logic thf, trf, th_fall, th_rise, tr_tog;
    assign thf     = flt_q[0];
    assign trf     = flt_q[1];
    // Edges are seen one CE after the filter accepts a level, which gives
    // the one-CE acknowledge latency on TL.
    assign th_fall =  prv_q[0] & ~thf;
    assign th_rise = ~prv_q[0] &  thf;
    assign tr_tog  =  prv_q[1] ^  trf;

    // ------------------------------------------------------------------
    // Snapshot and nibble map
    // ------------------------------------------------------------------
    logic [12*NPADS-1:0] snap_btn_q, snap_btn_d;
    logic [NPADS-1:0]    snap_pres_q, snap_pres_d;
    logic [NPADS-1:0]    snap_six_q, snap_six_d;

    logic [IDXW-1:0]     idx_q, idx_d, idx_nx;
    logic [IDXW-1:0]     data_end;
    logic [3:0]          nib_nx;

    assign idx_nx = idx_q + 1'b1;

    // Nibble that belongs at idx_nx, and the index one past the last data
    // nibble. Present pads are packed back to back in ascending order.
    always_comb begin
        int         pos;
        logic [11:0] b;
        nib_nx = 4'hF;
        pos    = 4 + NPADS;
        b      = '1;
        if (idx_nx == IDXW'(1)) begin
            nib_nx = 4'hF;
        end else if (idx_nx < IDXW'(4)) begin
            nib_nx = 4'h0;
        end
        for (int p = 0; p < NPADS; p++) begin
            if (int'(idx_nx) == 4 + p) begin
                nib_nx = !snap_pres_q[p] ? 4'hF : (snap_six_q[p] ? 4'h1 : 4'h0);
            end
        end
        for (int p = 0; p < NPADS; p++) begin
            if (snap_pres_q[p]) begin
                b = snap_btn_q[12*p +: 12];
                if (int'(idx_nx) == pos) begin
                    nib_nx = {b[3], b[2], b[1], b[0]};
                end
                if (int'(idx_nx) == pos + 1) begin
                    nib_nx = {b[7], b[4], b[6], b[5]};
                end
                if (snap_six_q[p] && int'(idx_nx) == pos + 2) begin
                    nib_nx = {b[8], b[9], b[10], b[11]};
                end
                pos = pos + (snap_six_q[p] ? 3 : 2);
            end
        end
        data_end = IDXW'(pos);
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [3:0]      do_q, do_d;
    logic            tl_q, tl_d;
    logic            active_q, active_d;
    logic [TMOW-1:0] tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        do_d        = do_q;
        tl_d        = tl_q;
        tmo_d       = tmo_q;
        snap_btn_d  = snap_btn_q;
        snap_pres_d = snap_pres_q;
        snap_six_d  = snap_six_q;

        case (state_q)
            ST_IDLE: begin
                do_d  = 4'h3;
                tl_d  = 1'b1;
                idx_d = '0;
                tmo_d = '0;
                // A TR toggle coinciding with the fall is simply not counted.
                if (th_fall) begin
                    state_d     = ST_SEQ;
                    tl_d        = trf;
                    snap_btn_d  = PAD_BTN;
                    snap_pres_d = PAD_PRESENT;
                    snap_six_d  = PAD_6BTN;
                end
            end
            ST_SEQ, ST_DONE: begin
                if (th_rise) begin
                    // TH rise takes priority over a simultaneous TR toggle.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    do_d    = 4'h3;
                    tl_d    = 1'b1;
                    tmo_d   = '0;
                end else if (tr_tog) begin
                    tmo_d = '0;
                    tl_d  = trf;
                    if (state_q == ST_SEQ) begin
                        idx_d = idx_nx;
                        if (idx_nx >= data_end) begin
                            state_d = ST_DONE;
                            do_d    = 4'hF;
                        end else begin
                            do_d    = nib_nx;
                        end
                    end else begin
                        do_d = 4'hF;
                    end
                end else if (!thf && tmo_q == TMOW'(TMO)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    do_d    = 4'h3;
                    tl_d    = 1'b1;
                    tmo_d   = '0;
                end else if (tmo_q != TMOW'(TMO)) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                do_d    = 4'h3;
                tl_d    = 1'b1;
                tmo_d   = '0;
            end
        endcase

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flt_q       <= 2'b11;
            prv_q       <= 2'b11;
            fcnt_q[0]   <= '0;
            fcnt_q[1]   <= '0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            do_q        <= 4'h3;
            tl_q        <= 1'b1;
            active_q    <= 1'b0;
            tmo_q       <= '0;
            snap_btn_q  <= '1;
            snap_pres_q <= '0;
            snap_six_q  <= '0;
        end else if (CE) begin
            flt_q       <= flt_d;
            prv_q       <= prv_d;
            fcnt_q[0]   <= fcnt_d[0];
            fcnt_q[1]   <= fcnt_d[1];
            state_q     <= state_d;
            idx_q       <= idx_d;
            do_q        <= do_d;
            tl_q        <= tl_d;
            active_q    <= active_d;
            tmo_q       <= tmo_d;
            snap_btn_q  <= snap_btn_d;
            snap_pres_q <= snap_pres_d;
            snap_six_q  <= snap_six_d;
        end
    end

    assign DO     = do_q;
    assign TL     = tl_q;
    assign ACTIVE = active_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_multitap.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_multitap
// Purpose  : Self-checking bench for gen_multitap (NPADS=4, short TMO).
//            Table of pad configurations with expected nibble streams, plus
//            hand-written sequences for snapshot, glitch, CE, timeout,
//            simultaneous-edge and reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_multitap;

    localparam int NP     = 4;
    localparam int TMO_T  = 40;
    localparam int FILT_T = 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          ce   = 1'b1;
    logic          th   = 1'b1;
    logic          tr   = 1'b1;
    logic [47:0]   btn  = '1;
    logic [3:0]    pres = '0;
    logic [3:0]    six  = '0;
    logic [3:0]    do_o;
    logic          tl_o;
    logic          act_o;

    int checks = 0;
    int errors = 0;

    gen_multitap #(.NPADS(NP), .TMO(TMO_T), .FILT(FILT_T)) dut (
        .RESET       (rst),
        .CLK         (clk),
        .CE          (ce),
        .TH          (th),
        .TR          (tr),
        .PAD_BTN     (btn),
        .PAD_PRESENT (pres),
        .PAD_6BTN    (six),
        .DO          (do_o),
        .TL          (tl_o),
        .ACTIVE      (act_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0]       btn;
        logic [3:0]        pres;
        logic [3:0]        six;
        logic [0:19][3:0]  exp;
        int                n;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tl(input string name);
        int k = 0;
        while (tl_o !== tr && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (tl_o !== tr) begin
            errors++;
            $display("FAIL %s ack timeout: TL %b expected %b", name, tl_o, tr);
        end
    endtask

    task automatic toggle_tr(input string name);
        tr = ~tr;
        wait_tl(name);
    endtask

    task automatic wait_active(input string name, input logic v);
        int k = 0;
        while (act_o !== v && k < 20) begin
            tick(1);
            k++;
        end
        chk(name, {3'b0, act_o}, {3'b0, v});
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1);
    end

    initial begin
        // idx0 is the leftmost nibble of each exp literal
        vecs[0] = '{btn: '1, pres: 4'b0011, six: 4'b0010,
                    exp: 80'h3F0001FFFFFFF0000000, n: 13};
        vecs[1] = '{btn: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFEE}, pres: 4'b0011, six: 4'b0010,
                    exp: 80'h3F0001FFEBFFF0000000, n: 13};
        vecs[2] = '{btn: {12'hFFF, 12'h7F7, 12'hF7F, 12'hFFF}, pres: 4'b1111, six: 4'b0101,
                    exp: 80'h3F001010FFFF77FEFF00, n: 18};
        vecs[3] = '{btn: '0, pres: 4'b0000, six: 4'b1111,
                    exp: 80'h3F00FFFF000000000000, n: 8};

        // Reset state
        tick(3);
        rst = 1'b0;
        tick(3);
        chk("reset DO", do_o, 4'h3);
        chk("reset TL", {3'b0, tl_o}, 4'h1);
        chk("reset ACTIVE", {3'b0, act_o}, 4'h0);

        // Table-driven full sequences
        for (int v = 0; v < 4; v++) begin
            btn  = vecs[v].btn;
            pres = vecs[v].pres;
            six  = vecs[v].six;
            th   = 1'b1;
            tr   = 1'b1;
            tick(6);
            chk($sformatf("v%0d idle DO", v), do_o, 4'h3);
            th = 1'b0;
            wait_active($sformatf("v%0d start", v), 1'b1);
            chk($sformatf("v%0d idx0", v), do_o, vecs[v].exp[0]);
            chk($sformatf("v%0d TL start", v), {3'b0, tl_o}, {3'b0, tr});
            for (int k = 1; k < vecs[v].n; k++) begin
                toggle_tr($sformatf("v%0d t%0d", v, k));
                chk($sformatf("v%0d idx%0d", v, k), do_o, vecs[v].exp[k]);
            end
            toggle_tr($sformatf("v%0d end", v));
            chk($sformatf("v%0d DONE DO", v), do_o, 4'hF);
            chk($sformatf("v%0d DONE ACTIVE", v), {3'b0, act_o}, 4'h1);
            toggle_tr($sformatf("v%0d done2", v));
            chk($sformatf("v%0d DONE hold", v), do_o, 4'hF);
            th = 1'b1;
            tick(5);
            chk($sformatf("v%0d exit ACTIVE", v), {3'b0, act_o}, 4'h0);
            chk($sformatf("v%0d exit DO", v), do_o, 4'h3);
        end

        // Snapshot: inputs changed after TH fall must be ignored
        btn = '1; pres = 4'b0011; six = 4'b0000; tr = 1'b1;
        tick(4);
        th = 1'b0;
        wait_active("snap start", 1'b1);
        btn = '0; pres = 4'b0000;
        for (int k = 1; k <= 4; k++) toggle_tr("snap t");
        chk("snap type pad0", do_o, 4'h0);
        for (int k = 5; k <= 8; k++) toggle_tr("snap t");
        chk("snap pad0 dir", do_o, 4'hF);
        toggle_tr("snap t9");
        chk("snap pad0 btn", do_o, 4'hF);
        th = 1'b1;
        tick(5);

        // Short TR glitch, CE gating, then TH rise with TR toggle together
        btn = '1; pres = 4'b0011; six = 4'b0010; tr = 1'b1;
        tick(4);
        th = 1'b0;
        wait_active("glitch start", 1'b1);
        for (int k = 1; k <= 5; k++) toggle_tr("glitch t");
        chk("glitch idx5", do_o, 4'h1);
        tr = ~tr;
        tick(1);
        tr = ~tr;
        tick(6);
        chk("glitch DO held", do_o, 4'h1);
        chk("glitch TL held", {3'b0, tl_o}, {3'b0, tr});
        ce = 1'b0;
        tr = ~tr;
        tick(6);
        chk("ce0 DO held", do_o, 4'h1);
        chk("ce0 TL held", {3'b0, tl_o}, {3'b0, ~tr});
        ce = 1'b1;
        wait_tl("ce1 ack");
        chk("ce1 idx6", do_o, 4'hF);
        th = 1'b1;
        tr = ~tr;
        tick(6);
        chk("rise+tog ACTIVE", {3'b0, act_o}, 4'h0);
        chk("rise+tog DO", do_o, 4'h3);
        chk("rise+tog TL", {3'b0, tl_o}, 4'h1);

        // Timeout
        tr = 1'b1;
        tick(4);
        th = 1'b0;
        wait_active("tmo start", 1'b1);
        toggle_tr("tmo t1");
        toggle_tr("tmo t2");
        chk("tmo idx2", do_o, 4'h0);
        tick(TMO_T - 3);
        chk("tmo not yet", {3'b0, act_o}, 4'h1);
        tick(10);
        chk("tmo ACTIVE", {3'b0, act_o}, 4'h0);
        chk("tmo DO", do_o, 4'h3);
        chk("tmo TL", {3'b0, tl_o}, 4'h1);
        th = 1'b1;
        tick(5);
        th = 1'b0;
        wait_active("restart", 1'b1);
        chk("restart idx0", do_o, 4'h3);
        toggle_tr("restart t1");
        chk("restart idx1", do_o, 4'hF);

        // Async reset mid-sequence
        toggle_tr("rst t2");
        chk("rst idx2", do_o, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst ACTIVE", {3'b0, act_o}, 4'h0);
        chk("async rst DO", do_o, 4'h3);
        chk("async rst TL", {3'b0, tl_o}, 4'h1);
        th = 1'b1;
        tr = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        chk("post rst ACTIVE", {3'b0, act_o}, 4'h0);
        chk("post rst DO", do_o, 4'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
